multiplicador_mantiza_secuencial: RTL and testbench

Parametrised iterative multiplier for the mantissa datapath of the floating-point multiplier. It multiplies two stored mantissas with their implicit leading 1, over NB_MANT+1 shift-add cycles. It then normalises the product, applies the selected rounding mode and reports an exponent-increment flag and an inexact flag. Operands enter and results leave through valid/ready handshakes, so the block sits between the operand unpacker and the exponent adjust stage.

---
 rtl/multiplicador_mantiza_secuencial.sv | 143 ++++++++++++++
 tb/tb_multiplicador_mantiza_secuencial.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplicador_mantiza_secuencial.sv
// Purpose : iterative (shift-add) mantissa multiplier with normalise + round for the FP multiplier.
// Latency : NB_MANT+2 cycles from acceptance to o_valid; initiation interval NB_MANT+4 cycles.
// Backpr. : o_ready only in IDLE; result held on o_valid until i_ready, i_ready ignored otherwise.
//
// Ports:
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_valid / o_ready                operand handshake (i_mantiza_1, i_mantiza_2 = stored fractions)
//   o_valid / i_ready                result handshake
//   o_mantiza                        normalised, rounded product fraction (hidden 1 dropped)
//   o_aviso_exponente                exponent must be incremented by one
//   o_inexacto                       nonzero bits were discarded by normalisation
module multiplicador_mantiza_secuencial #(
    parameter int NB_MANT = 8,
    parameter int ROUND   = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_MANT-1:0] i_mantiza_1,
    input  logic [NB_MANT-1:0] i_mantiza_2,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_MANT-1:0] o_mantiza,
    output logic               o_aviso_exponente,
    output logic               o_inexacto
);

    localparam int NB_OP  = NB_MANT + 1;
    localparam int NB_ACC = 2 * NB_MANT + 2;
    localparam int NB_CNT = $clog2(NB_MANT + 1);

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    state_t state, state_next;

    logic [NB_OP-1:0]  multiplicando;
    logic [NB_OP-1:0]  multiplicador;
    logic [NB_ACC-1:0] acc;
    logic [NB_CNT-1:0] cnt;

    logic              accept;
    logic              last_iter;
    logic [NB_OP:0]    suma;
    logic [NB_ACC-1:0] acc_next;

    logic [NB_MANT-1:0] cand;
    logic               guard;
    logic               sticky;
    logic               shift;
    logic               round_up;
    logic [NB_MANT:0]   rounded;

    assign accept    = i_valid && o_ready;
    assign last_iter = (cnt == NB_CNT'(NB_MANT));

    // Partial product enters the upper half; the carry bit of the add becomes
    // the new MSB after the right shift, so nothing is lost.
    assign suma     = {1'b0, acc[NB_ACC-1 -: NB_OP]}
                    + ({(NB_OP+1){multiplicador[0]}} & {1'b0, multiplicando});
    assign acc_next = {suma, acc[NB_MANT:1]};

    // Normalisation: product lies in [1,4), so at most one position of shift.
    always_comb begin
        shift = acc[NB_ACC-1];
        if (shift) begin
            cand   = acc[2*NB_MANT -: NB_MANT];
            guard  = acc[NB_MANT];
            sticky = |acc[NB_MANT-1:0];
        end else begin
            cand   = acc[2*NB_MANT-1 -: NB_MANT];
            guard  = acc[NB_MANT-1];
            sticky = |acc[NB_MANT-2:0];
        end
        round_up = (ROUND == 1) && guard && (sticky || cand[0]);
        rounded  = {1'b0, cand} + {{NB_MANT{1'b0}}, round_up};
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = MULT;
            MULT:    if (last_iter) state_next = NORM;
            NORM:                   state_next = DONE;
            DONE:    if (i_ready)   state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        o_ready = (state == IDLE);
        o_valid = (state == DONE);
    end

    // Datapath and registered results
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            multiplicando     <= '0;
            multiplicador     <= '0;
            acc               <= '0;
            cnt               <= '0;
            o_mantiza         <= '0;
            o_aviso_exponente <= 1'b0;
            o_inexacto        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        multiplicando <= {1'b1, i_mantiza_1};
                        multiplicador <= {1'b1, i_mantiza_2};
                        acc           <= '0;
                        cnt           <= '0;
                    end
                end
                MULT: begin
                    acc           <= acc_next;
                    multiplicador <= multiplicador >> 1;
                    cnt           <= cnt + 1'b1;
                end
                NORM: begin
                    // A rounding carry out means 1.111..1 rounded to 10.000..0.
                    o_mantiza         <= rounded[NB_MANT] ? '0 : rounded[NB_MANT-1:0];
                    o_aviso_exponente <= shift | rounded[NB_MANT];
                    o_inexacto        <= guard | sticky;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador_mantiza_secuencial.sv
`timescale 1ns/1ps
module tb_multiplicador_mantiza_secuencial;

    typedef struct packed {
        logic [7:0] m;
        logic       av;
        logic       ix;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index k: 0 = N8/trunc, 1 = N8/RNE, 2 = N4/trunc, 3 = N4/RNE
    logic       vld    [4];
    logic       rdy_dn [4];
    logic [7:0] a_in   [4];
    logic [7:0] b_in   [4];

    logic       rdy_up [4];
    logic       vld_out[4];
    logic       aviso  [4];
    logic       inex   [4];
    logic [7:0] mant   [4];

    logic       r0, r1, r2, r3, v0, v1, v2, v3, e0, e1, e2, e3, x0, x1, x2, x3;
    logic [7:0] m0, m1;
    logic [3:0] m2, m3;

    res_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    multiplicador_mantiza_secuencial #(.NB_MANT(8), .ROUND(0)) u_n8_r0 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[0]), .o_ready(r0),
        .i_mantiza_1(a_in[0]), .i_mantiza_2(b_in[0]), .o_valid(v0), .i_ready(rdy_dn[0]),
        .o_mantiza(m0), .o_aviso_exponente(e0), .o_inexacto(x0));
    multiplicador_mantiza_secuencial #(.NB_MANT(8), .ROUND(1)) u_n8_r1 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[1]), .o_ready(r1),
        .i_mantiza_1(a_in[1]), .i_mantiza_2(b_in[1]), .o_valid(v1), .i_ready(rdy_dn[1]),
        .o_mantiza(m1), .o_aviso_exponente(e1), .o_inexacto(x1));
    multiplicador_mantiza_secuencial #(.NB_MANT(4), .ROUND(0)) u_n4_r0 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[2]), .o_ready(r2),
        .i_mantiza_1(a_in[2][3:0]), .i_mantiza_2(b_in[2][3:0]), .o_valid(v2), .i_ready(rdy_dn[2]),
        .o_mantiza(m2), .o_aviso_exponente(e2), .o_inexacto(x2));
    multiplicador_mantiza_secuencial #(.NB_MANT(4), .ROUND(1)) u_n4_r1 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld[3]), .o_ready(r3),
        .i_mantiza_1(a_in[3][3:0]), .i_mantiza_2(b_in[3][3:0]), .o_valid(v3), .i_ready(rdy_dn[3]),
        .o_mantiza(m3), .o_aviso_exponente(e3), .o_inexacto(x3));

    always_comb begin
        rdy_up[0] = r0; rdy_up[1] = r1; rdy_up[2] = r2; rdy_up[3] = r3;
        vld_out[0] = v0; vld_out[1] = v1; vld_out[2] = v2; vld_out[3] = v3;
        aviso[0] = e0; aviso[1] = e1; aviso[2] = e2; aviso[3] = e3;
        inex[0] = x0; inex[1] = x1; inex[2] = x2; inex[3] = x3;
        mant[0] = m0; mant[1] = m1; mant[2] = {4'h0, m2}; mant[3] = {4'h0, m3};
    end

    function automatic int nb(input int k);
        return (k < 2) ? 8 : 4;
    endfunction

    // Reference: exact integer product, rounded by remainder vs. half-ulp.
    function automatic res_t model(input int k, input logic [7:0] a, input logic [7:0] b);
        int     n, sh;
        longint one, p, q, r, half;
        res_t   e;
        n    = nb(k);
        one  = 1;
        p    = ((one << n) + (longint'(a) % (one << n))) * ((one << n) + (longint'(b) % (one << n)));
        sh   = (p >= (one << (2*n+1))) ? 1 : 0;
        q    = p >> (n + sh);
        r    = p - (q << (n + sh));
        half = one << (n + sh - 1);
        e.ix = (r != 0);
        if ((k % 2) == 1 && (r > half || (r == half && q[0]))) q = q + 1;
        if (q == (one << (n + 1))) begin
            e.m  = 8'h00;
            e.av = 1'b1;
        end else begin
            e.m  = 8'(q - (one << n));
            e.av = (sh == 1);
        end
        return e;
    endfunction

    // Handshake driver: returns the result seen when o_valid rises, the cycles
    // from the acceptance edge, and whether o_ready was seen while busy.
    task automatic do_op(input int k, input logic [7:0] a, input logic [7:0] b, input bit rel,
                         output res_t obs, output int lat, output bit viol);
        int g;
        viol = 1'b0;
        @(negedge clk);
        a_in[k] = a;
        b_in[k] = b;
        vld[k]  = 1'b1;
        g = 0;
        while (!rdy_up[k] && g < 200) begin @(negedge clk); g++; end
        @(posedge clk);
        #1 vld[k] = 1'b0;
        lat = 0;
        while (!vld_out[k] && lat < 200) begin
            if (rdy_up[k]) viol = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        obs = {mant[k], aviso[k], inex[k]};
        if (rel) begin
            rdy_dn[k] = 1'b1;
            @(posedge clk); #1;
            rdy_dn[k] = 1'b0;
            if (vld_out[k] || !rdy_up[k]) viol = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            vld[k] = 1'b0; rdy_dn[k] = 1'b0; a_in[k] = 8'h00; b_in[k] = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({vld_out[k], mant[k], aviso[k], inex[k]} !== 11'h0) begin
                n_bad++;
                $display("FAIL reset_outputs k=%0d got vld=%b m=%h av=%b ix=%b want all 0",
                         k, vld_out[k], mant[k], aviso[k], inex[k]);
            end
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (rdy_up[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_ready k=%0d got %b want 1", k, rdy_up[k]);
            end
        end
    endtask

    task automatic test_latency();
        res_t obs, e;
        int   lat;
        bit   viol;
        sb.push_back(res_t'({8'h00, 1'b0, 1'b0}));
        do_op(0, 8'h00, 8'h00, 1'b1, obs, lat, viol);
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL zero_result got %h want %h", obs, e);
        end
        n_cmp++;
        if (lat !== 10) begin
            n_bad++;
            $display("FAIL latency got %0d want 10", lat);
        end
        n_cmp++;
        if (viol) begin
            n_bad++;
            $display("FAIL handshake_overlap got violation want none");
        end
    endtask

    task automatic test_vectors();
        int         tk[6] = '{0, 1, 0, 1, 3, 2};
        logic [7:0] ta[6] = '{8'h80, 8'h80, 8'hFF, 8'hFF, 8'h05, 8'h05};
        logic [7:0] tb[6] = '{8'h80, 8'h80, 8'hFF, 8'hFF, 8'h08, 8'h08};
        res_t       te[6] = '{res_t'(10'b00100000_1_0), res_t'(10'b00100000_1_0),
                              res_t'(10'b11111110_1_1), res_t'(10'b11111110_1_1),
                              res_t'(10'b00000000_1_1), res_t'(10'b00001111_0_1)};
        res_t obs, e;
        int   lat;
        bit   viol;
        for (int i = 0; i < 6; i++) begin
            sb.push_back(te[i]);
            do_op(tk[i], ta[i], tb[i], 1'b1, obs, lat, viol);
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL vector%0d k=%0d got %h want %h", i, tk[i], obs, e);
            end
            n_cmp++;
            if (lat !== nb(tk[i]) + 2 || viol) begin
                n_bad++;
                $display("FAIL vector%0d_timing k=%0d got lat=%0d viol=%b want lat=%0d viol=0",
                         i, tk[i], lat, viol, nb(tk[i]) + 2);
            end
        end
    endtask

    task automatic test_backpressure();
        res_t obs, e, now;
        int   lat;
        bit   viol;
        sb.push_back(res_t'({8'hFE, 1'b1, 1'b1}));
        do_op(0, 8'hFF, 8'hFF, 1'b0, obs, lat, viol);
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL bp_result got %h want %h", obs, e);
        end
        a_in[0] = 8'h01;
        b_in[0] = 8'h01;
        vld[0]  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            now = {mant[0], aviso[0], inex[0]};
            n_cmp++;
            if (vld_out[0] !== 1'b1 || rdy_up[0] !== 1'b0 || now !== e) begin
                n_bad++;
                $display("FAIL bp_hold cycle=%0d got vld=%b rdy=%b res=%h want vld=1 rdy=0 res=%h",
                         c, vld_out[0], rdy_up[0], now, e);
            end
        end
        vld[0]    = 1'b0;
        rdy_dn[0] = 1'b1;
        @(posedge clk); #1;
        rdy_dn[0] = 1'b0;
        now = {mant[0], aviso[0], inex[0]};
        n_cmp++;
        if (vld_out[0] !== 1'b0 || rdy_up[0] !== 1'b1 || now !== e) begin
            n_bad++;
            $display("FAIL bp_release got vld=%b rdy=%b res=%h want vld=0 rdy=1 res=%h",
                     vld_out[0], rdy_up[0], now, e);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (rdy_up[0] !== 1'b1 || vld_out[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_ignored_valid got rdy=%b vld=%b want rdy=1 vld=0", rdy_up[0], vld_out[0]);
        end
    endtask

    task automatic test_reset_mid_mult();
        res_t obs, e;
        int   lat;
        bit   viol;
        int   g;
        @(negedge clk);
        a_in[0] = 8'h3C;
        b_in[0] = 8'hA5;
        vld[0]  = 1'b1;
        g = 0;
        while (!rdy_up[0] && g < 200) begin @(negedge clk); g++; end
        @(posedge clk);
        #1 vld[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({vld_out[0], mant[0], aviso[0], inex[0]} !== 11'h0) begin
            n_bad++;
            $display("FAIL midreset_outputs got vld=%b m=%h av=%b ix=%b want all 0",
                     vld_out[0], mant[0], aviso[0], inex[0]);
        end
        @(negedge clk) rst = 1'b0;
        #1;
        n_cmp++;
        if (rdy_up[0] !== 1'b1 || vld_out[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_ready got rdy=%b vld=%b want rdy=1 vld=0", rdy_up[0], vld_out[0]);
        end
        sb.push_back(res_t'({8'h20, 1'b1, 1'b0}));
        do_op(0, 8'h80, 8'h80, 1'b1, obs, lat, viol);
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e || lat !== 10) begin
            n_bad++;
            $display("FAIL midreset_followup got res=%h lat=%0d want res=%h lat=10", obs, lat, e);
        end
    endtask

    task automatic test_back_to_back();
        longint     t_prev, t_now;
        res_t       e, obs;
        logic [7:0] a, b;
        int         g;
        t_prev = 0;
        rdy_dn[1] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            sb.push_back(model(1, a, b));
            a_in[1] = a;
            b_in[1] = b;
            vld[1]  = 1'b1;
            g = 0;
            while (!rdy_up[1] && g < 200) begin @(negedge clk); g++; end
            @(posedge clk);
            t_now = $time;
            #1;
            g = 0;
            while (!vld_out[1] && g < 200) begin @(negedge clk); g++; end
            obs = {mant[1], aviso[1], inex[1]};
            e = sb.pop_front();
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL b2b_result j=%0d a=%h b=%h got %h want %h", j, a, b, obs, e);
            end
            if (j > 0) begin
                n_cmp++;
                if (t_now - t_prev != 120) begin
                    n_bad++;
                    $display("FAIL b2b_interval j=%0d got %0d cycles want 12", j, (t_now - t_prev) / 10);
                end
            end
            t_prev = t_now;
        end
        vld[1] = 1'b0;
        @(posedge clk); #1;
        rdy_dn[1] = 1'b0;
    endtask

    task automatic test_random();
        res_t       e, obs;
        logic [7:0] a, b;
        int         lat;
        bit         viol;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                a = 8'($urandom);
                b = 8'($urandom);
                if (i == 0) begin a = 8'hFF; b = 8'h01; end
                sb.push_back(model(k, a, b));
                do_op(k, a, b, 1'b1, obs, lat, viol);
                e = sb.pop_front();
                n_cmp++;
                if (obs !== e || lat !== nb(k) + 2 || viol) begin
                    n_bad++;
                    $display("FAIL random k=%0d a=%h b=%h got res=%h lat=%0d viol=%b want res=%h lat=%0d",
                             k, a, b, obs, lat, viol, e, nb(k) + 2);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_backpressure();
        test_reset_mid_mult();
        test_back_to_back();
        test_random();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
